// File: rtl/branch_pred_resolve_queue.sv
// In-order queue of fetched conditional branches and their predictions. It pops the oldest
// branch on resolve, emits the registered table update, and emits a one-cycle mispredict/redirect pulse.
module branch_pred_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [31:0]      push_pc,
    input  logic             push_pred,
    output logic             push_ready,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    input  logic [31:0]      resolve_target,
    input  logic             flush,
    output logic             upd_pred_state,
    output logic [IDX_W-1:0] lpt_addr,
    output logic             actual_brch_result,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             resolve_err,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [31:0]      ent_pc   [DEPTH];
    logic             ent_pred [DEPTH];

    logic             empty;
    logic             pop;
    logic             push_fire;
    logic             mispred_now;
    logic             clear_q;
    logic [31:0]      head_pc;
    logic             head_pred;

    logic             upd_reg;
    logic [IDX_W-1:0] lpt_addr_reg;
    logic             actual_reg;
    logic             mispredict_reg;
    logic [31:0]      redirect_reg;
    logic             resolve_err_reg;

    assign empty       = (count_reg == '0);
    assign push_ready  = !rst && (count_reg < CNT_W'(DEPTH));
    assign pop         = resolve_valid && !empty;
    assign head_pc     = ent_pc[head_reg];
    assign head_pred   = ent_pred[head_reg];
    assign mispred_now = pop && (head_pred != resolve_taken);
    // A mispredicted branch kills everything younger, including a push in the same cycle.
    assign clear_q     = flush || mispred_now;
    assign push_fire   = push_valid && push_ready && !clear_q;

    // Per-entry storage; only the entry under the tail pointer is written.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_ent
            logic [31:0] pc_reg;
            logic        pred_reg;

            always_ff @(posedge clk) begin
                if (push_fire && (tail_reg == PTR_W'(gi))) begin
                    pc_reg   <= push_pc;
                    pred_reg <= push_pred;
                end
            end

            assign ent_pc[gi]   = pc_reg;
            assign ent_pred[gi] = pred_reg;
        end
    endgenerate

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (clear_q) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (pop) begin
                head_next = head_reg + PTR_W'(1);
            end
            if (push_fire) begin
                tail_next = tail_reg + PTR_W'(1);
            end
            count_next = count_reg + CNT_W'(push_fire) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Output stage: strobes are one cycle; the data fields hold their last value between updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_reg         <= 1'b0;
            lpt_addr_reg    <= '0;
            actual_reg      <= 1'b0;
            mispredict_reg  <= 1'b0;
            redirect_reg    <= '0;
            resolve_err_reg <= 1'b0;
        end else begin
            upd_reg         <= pop;
            mispredict_reg  <= mispred_now;
            resolve_err_reg <= resolve_valid && empty;
            if (pop) begin
                lpt_addr_reg <= head_pc[IDX_W+1:2];
                actual_reg   <= resolve_taken;
                redirect_reg <= resolve_taken ? resolve_target : (head_pc + 32'd4);
            end
        end
    end

    assign upd_pred_state     = upd_reg;
    assign lpt_addr           = lpt_addr_reg;
    assign actual_brch_result = actual_reg;
    assign mispredict         = mispredict_reg;
    assign redirect_pc        = redirect_reg;
    assign resolve_err        = resolve_err_reg;
    assign count              = count_reg;

endmodule
